seq_mult16: RTL and testbench

//   Sequential unsigned shift-and-add multiplier for the ALU multiply path.

---
 rtl/alu_pkg.sv | 12 +
 rtl/add16c.sv | 15 +
 rtl/seq_mult16.sv | 102 ++++++++++
 tb/tb_seq_mult16.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the multiplier FSM state encoding.
package alu_pkg;

    localparam int ALU_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add16c.sv
// Combinational WIDTH-bit adder with carry-out; carry-in is fixed at zero.
module add16c
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_mult16.sv
// Sequential unsigned shift-and-add multiplier: one add per cycle, WIDTH cycles per product,
// valid/ready handshakes on operand and result sides.
module seq_mult16
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               last_iter;

    // Add the multiplicand into the high half when the current multiplier bit is set,
    // then shift the whole accumulator right, keeping the carry as the new MSB.
    assign add_b    = acc[0] ? mcand : '0;
    assign acc_next = {add_cout, add_sum, acc[WIDTH-1:1]};

    add16c #(.WIDTH(WIDTH)) u_add (
        .a    (acc[2*WIDTH-1:WIDTH]),
        .b    (add_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign last_iter = (state == ST_RUN) && (cnt == CNT_W'(WIDTH - 1));

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_RUN);
    assign out_valid = (state == ST_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: next-state gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_iter) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // product only updates on the final iteration, so a reset mid-run never exposes a
    // partial product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            mcand   <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        acc   <= {{WIDTH{1'b0}}, b};
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        product <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult16.sv
// Directed plus randomised bench for seq_mult16 with a queue-based result scoreboard.
module tb_seq_mult16;
    import alu_pkg::*;

    localparam int W   = ALU_W;
    localparam int LAT = W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [2*W-1:0] product;

    int n_checks = 0;
    int n_fails  = 0;
    logic [2*W-1:0] sb_q[$];

    seq_mult16 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xe;
        logic [2*W-1:0] ye;
        xe = {{W{1'b0}}, x};
        ye = {{W{1'b0}}, y};
        return xe * ye;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("send_in_ready", in_ready, 1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        sb_q.push_back(ref_mul(av, bv));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, checks latency, pops the scoreboard and compares the product.
    task automatic await_result(input string tag);
        int k;
        logic [2*W-1:0] exp_p;
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, LAT);
        check({tag, "_sb_nonempty"}, (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
            exp_p = sb_q.pop_front();
            check({tag, "_product"}, product, exp_p);
        end
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [2*W-1:0] held;
        logic [2*W-1:0] exp_p;
        int got;
        int sent;
        int cyc;

        // Reset state
        @(negedge clk);
        expect_idle("reset");
        check("reset_product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: small operands, consumer always ready
        out_ready = 1'b1;
        send(16'd3, 16'd5);
        check("t1_busy", busy, 1);
        check("t1_in_ready_run", in_ready, 0);
        await_result("t1");
        check("t1_value", product, 32'h0000_000F);
        @(negedge clk);
        expect_idle("t1_after");

        // 2: all-ones operands exercise the adder carry-out
        send(16'hFFFF, 16'hFFFF);
        await_result("t2");
        check("t2_value", product, 32'hFFFE_0001);
        @(negedge clk);

        // 3: zero operands on either side
        send(16'h0000, 16'h1234);
        await_result("t3a");
        check("t3a_value", product, 0);
        @(negedge clk);
        send(16'h1234, 16'h0000);
        await_result("t3b");
        check("t3b_value", product, 0);
        @(negedge clk);

        // 4: backpressure holds DONE stable
        out_ready = 1'b0;
        send(16'h00FF, 16'h0100);
        await_result("t4");
        held = product;
        check("t4_value", held, 32'h0000_FF00);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 16'hAAAA;
            b = 16'h5555;
            @(negedge clk);
            check("t4_hold_product", product, 32'h0000_FF00);
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        expect_idle("t4_release");
        out_ready = 1'b0;

        // 5: reset in the middle of a run
        send(16'd7, 16'd9);
        repeat (7) @(negedge clk);
        check("t5_busy_before_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        expect_idle("t5_reset");
        check("t5_reset_product", product, 0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        send(16'd2, 16'd2);
        await_result("t5_next");
        check("t5_value", product, 4);
        @(negedge clk);

        // 6: in_valid held high with fresh random operands every cycle; only the
        // operands present while in IDLE may produce a result.
        got  = 0;
        sent = 0;
        cyc  = 0;
        while (got < 20 && cyc < 5000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (sb_q.size() != 0) begin
                    exp_p = sb_q.pop_front();
                    check("t6_product", product, exp_p);
                end else begin
                    check("t6_unexpected_result", 1, 0);
                end
                got++;
            end
            a = W'($urandom);
            b = W'($urandom);
            in_valid = (sent < 20);
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_mul(a, b));
                sent++;
            end
            if (in_ready && busy) check("t6_ready_while_busy", 1, 0);
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t6_results", got, 20);
        check("t6_sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
